// File: rtl/div_iter_unit.sv
// -----------------------------------------------------------------------------
// div_iter_unit
//
// Multi-cycle radix-2 restoring divider for the RV64M divide/remainder group
// (DIV/DIVU/REM/REMU and their W variants). A start in IDLE latches the
// operands. Divide-by-zero and signed overflow finish on the next cycle.
// Every other case runs one quotient bit per cycle: 64 steps for full width,
// 32 steps for word mode. A final cycle applies the result signs.
//
// Ports:
//   clk        clock
//   reset_n    asynchronous active-low reset
//   start      request (decoder div_start qualified by execute valid)
//   sign       1 = signed operation, 0 = unsigned
//   word       1 = 32-bit W variant (operates on low XLEN/2 bits)
//   dividend   rs1 value
//   divisor    rs2 value
//   flush      abort any operation; results are left untouched
//   busy       high while iterating / fixing up signs (CALC, FIX)
//   done       one-cycle pulse, quotient/remainder valid
//   quotient   result, held until overwritten by the next completion
//   remainder  result, held until overwritten by the next completion
//
// Build option:
//   DIV_EARLY_OUT_EN  when defined, |dividend| < |divisor| (divisor != 0)
//                     completes in one cycle with quotient 0 and remainder =
//                     the dividend. When undefined, that case takes the
//                     normal iterative path and gives the same result.
// -----------------------------------------------------------------------------
module div_iter_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            sign,
   input  logic            word,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam int HALF = XLEN / 2;
   localparam int CW   = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] quo_q;
   logic [XLEN-1:0] dvs_q;
   logic            negq_q;
   logic            negr_q;
   logic            word_q;
   logic            busy_q;
   logic            done_q;
   logic [XLEN-1:0] quotient_q;
   logic [XLEN-1:0] remainder_q;

   // Sign-extend the low half into the full width when en is set.
   function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] x, input logic en);
      return en ? {{HALF{x[HALF-1]}}, x[HALF-1:0]} : x;
   endfunction

   // ---------------------------------------------------------------- operands
   logic [XLEN-1:0] a_eff, b_eff;
   logic [XLEN-1:0] mag_a, mag_b;
   logic [XLEN-1:0] min_val;
   logic            sign_a, sign_b;
   logic            div_zero, ovf, early_out, fast_hit;
   logic [XLEN-1:0] fast_q_d, fast_r_d;
   logic [XLEN-1:0] quo_init;
   logic [CW-1:0]   cnt_init;

   always_comb begin
      a_eff = dividend;
      b_eff = divisor;
      if (word) begin
         a_eff = {{HALF{sign & dividend[HALF-1]}}, dividend[HALF-1:0]};
         b_eff = {{HALF{sign & divisor[HALF-1]}}, divisor[HALF-1:0]};
      end
      sign_a = sign & a_eff[XLEN-1];
      sign_b = sign & b_eff[XLEN-1];
      // The most negative value negates to itself. As an unsigned number that
      // is 2^(XLEN-1), which is exactly the magnitude the divider needs.
      mag_a  = sign_a ? -a_eff : a_eff;
      mag_b  = sign_b ? -b_eff : b_eff;

      // Most negative value of the effective width, after word-mode extension.
      min_val = word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                     : {1'b1, {(XLEN-1){1'b0}}};

      div_zero = (b_eff == '0);
      ovf      = sign && (a_eff == min_val) && (&b_eff);
`ifdef DIV_EARLY_OUT_EN
      early_out = !div_zero && (mag_a < mag_b);
`else
      early_out = 1'b0;
`endif
      fast_hit = div_zero | ovf | early_out;

      // Early-out and divide-by-zero both return the dividend as remainder.
      fast_q_d = '0;
      fast_r_d = wext(a_eff, word);
      if (div_zero) begin
         fast_q_d = '1;
      end else if (ovf) begin
         fast_q_d = a_eff;
         fast_r_d = '0;
      end

      // In word mode, park the 32 dividend bits in the upper half. The 32
      // shifts then move them into the remainder, and the quotient bits
      // collect in the lower half with zeros above them.
      quo_init = word ? {mag_a[HALF-1:0], {HALF{1'b0}}} : mag_a;
      cnt_init = word ? CW'(HALF - 1) : CW'(XLEN - 1);
   end

   // ----------------------------------------------------------- restoring step
   logic [XLEN:0]   rem_shift;
   logic            step_ok;
   logic [XLEN-1:0] rem_d, quo_d;

   always_comb begin
      // The shifted partial remainder can be up to XLEN+1 bits wide, so the
      // trial compare is done at that width. When the compare passes, the
      // difference is below the divisor and fits in XLEN bits.
      rem_shift = {rem_q, quo_q[XLEN-1]};
      step_ok   = (rem_shift >= {1'b0, dvs_q});
      rem_d     = step_ok ? (rem_shift[XLEN-1:0] - dvs_q) : rem_shift[XLEN-1:0];
      quo_d     = {quo_q[XLEN-2:0], step_ok};
   end

   // ----------------------------------------------------------------- fix-up
   logic [XLEN-1:0] sq_d, sr_d, fix_q_d, fix_r_d;

   always_comb begin
      sq_d    = negq_q ? -quo_q : quo_q;
      sr_d    = negr_q ? -rem_q : rem_q;
      // Word results are always sign-extended from bit 31, unsigned ops included.
      fix_q_d = wext(sq_d, word_q);
      fix_r_d = wext(sr_d, word_q);
   end

   // -------------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         negq_q      <= 1'b0;
         negr_q      <= 1'b0;
         word_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     negq_q <= sign_a ^ sign_b;
                     negr_q <= sign_a;
                     word_q <= word;
                     quo_q  <= quo_init;
                     rem_q  <= '0;
                     dvs_q  <= mag_b;
                     cnt_q  <= cnt_init;
                     if (fast_hit) begin
                        quotient_q  <= fast_q_d;
                        remainder_q <= fast_r_d;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                     end else begin
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                     end
                  end
               end
               CALC: begin
                  rem_q <= rem_d;
                  quo_q <= quo_d;
                  if (cnt_q == '0) begin
                     state_q <= FIX;
                  end else begin
                     cnt_q <= cnt_q - CW'(1);
                  end
               end
               FIX: begin
                  quotient_q  <= fix_q_d;
                  remainder_q <= fix_r_d;
                  done_q      <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= DONE;
               end
               DONE: begin
                  state_q <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// -----------------------------------------------------------------------------
// tb_div_iter_unit
//
// Directed bench for div_iter_unit. Each scenario task drives its own vectors
// and checks the results against hand-computed values. Cycle numbers count
// the start cycle as 0. Outputs are sampled 1 time unit after each rising
// clock edge.
// -----------------------------------------------------------------------------
module tb_div_iter_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        sign = 1'b0;
   logic        word = 1'b0;
   logic        flush = 1'b0;
   logic [63:0] dividend = '0;
   logic [63:0] divisor = '0;
   logic        busy;
   logic        done;
   logic [63:0] quotient;
   logic [63:0] remainder;

   int errors = 0;
   int checks = 0;

`ifdef DIV_EARLY_OUT_EN
   localparam int EARLY_LAT = 1;
`else
   localparam int EARLY_LAT = 66;
`endif

   always #5 clk = ~clk;

   div_iter_unit #(.XLEN(64)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .sign      (sign),
      .word      (word),
      .dividend  (dividend),
      .divisor   (divisor),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder)
   );

   // Holds start from cycle 0 until done is seen, as the decoder does.
   // dc is -1 if done never arrives within the bound.
   task automatic run_op(input logic s, input logic w, input logic [63:0] a,
                         input logic [63:0] b, output int dc, output int bc,
                         output logic bd);
      @(posedge clk); #1;
      start = 1'b1; sign = s; word = w; dividend = a; divisor = b;
      dc = -1; bc = 0; bd = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         if (busy === 1'b1) bc++;
         if (done === 1'b1) begin
            dc = c;
            bd = busy;
            break;
         end
      end
      start = 1'b0;
      $display("op sign=%0b word=%0b a=%h b=%h -> q=%h r=%h done_cycle=%0d busy_cycles=%0d",
               s, w, a, b, quotient, remainder, dc, bc);
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
      checks++; if (quotient !== 64'h0) begin errors++; $display("FAIL reset_quotient: got %h expected 0", quotient); end
      checks++; if (remainder !== 64'h0) begin errors++; $display("FAIL reset_remainder: got %h expected 0", remainder); end
      $display("reset released busy=%0b done=%0b q=%h r=%h", busy, done, quotient, remainder);
   endtask

   task automatic test_divu;
      int dc, bc; logic bd;
      run_op(1'b0, 1'b0, 64'd100, 64'd7, dc, bc, bd);
      checks++; if (dc !== 66) begin errors++; $display("FAIL divu_latency: got %0d expected 66", dc); end
      checks++; if (bc !== 65) begin errors++; $display("FAIL divu_busy_cycles: got %0d expected 65", bc); end
      checks++; if (bd !== 1'b0) begin errors++; $display("FAIL divu_busy_at_done: got %0b expected 0", bd); end
      checks++; if (quotient !== 64'd14) begin errors++; $display("FAIL divu_quotient: got %h expected %h", quotient, 64'd14); end
      checks++; if (remainder !== 64'd2) begin errors++; $display("FAIL divu_remainder: got %h expected %h", remainder, 64'd2); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL divu_done_pulse: got %0b expected 0", done); end
   endtask

   task automatic test_div_signed;
      int dc, bc; logic bd;
      run_op(1'b1, 1'b0, 64'hFFFFFFFFFFFFFF9C, 64'd7, dc, bc, bd);
      checks++; if (dc !== 66) begin errors++; $display("FAIL div_latency: got %0d expected 66", dc); end
      checks++; if (quotient !== 64'hFFFFFFFFFFFFFFF2) begin errors++; $display("FAIL div_quotient: got %h expected fffffffffffffff2", quotient); end
      checks++; if (remainder !== 64'hFFFFFFFFFFFFFFFE) begin errors++; $display("FAIL div_remainder: got %h expected fffffffffffffffe", remainder); end
   endtask

   task automatic test_fast_paths;
      int dc, bc; logic bd;
      run_op(1'b1, 1'b1, 64'h0000000080000000, 64'hFFFFFFFFFFFFFFFF, dc, bc, bd);
      checks++; if (dc !== 1) begin errors++; $display("FAIL divw_ovf_latency: got %0d expected 1", dc); end
      checks++; if (bc !== 0) begin errors++; $display("FAIL divw_ovf_busy: got %0d expected 0", bc); end
      checks++; if (quotient !== 64'hFFFFFFFF80000000) begin errors++; $display("FAIL divw_ovf_quotient: got %h expected ffffffff80000000", quotient); end
      checks++; if (remainder !== 64'h0) begin errors++; $display("FAIL divw_ovf_remainder: got %h expected 0", remainder); end

      run_op(1'b0, 1'b0, 64'd55, 64'd0, dc, bc, bd);
      checks++; if (dc !== 1) begin errors++; $display("FAIL remu_zero_latency: got %0d expected 1", dc); end
      checks++; if (quotient !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL remu_zero_quotient: got %h expected ffffffffffffffff", quotient); end
      checks++; if (remainder !== 64'd55) begin errors++; $display("FAIL remu_zero_remainder: got %h expected 37", remainder); end

      run_op(1'b1, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, dc, bc, bd);
      checks++; if (dc !== 1) begin errors++; $display("FAIL div_ovf_latency: got %0d expected 1", dc); end
      checks++; if (quotient !== 64'h8000000000000000) begin errors++; $display("FAIL div_ovf_quotient: got %h expected 8000000000000000", quotient); end
      checks++; if (remainder !== 64'h0) begin errors++; $display("FAIL div_ovf_remainder: got %h expected 0", remainder); end
   endtask

   task automatic test_early_out;
      int dc, bc; logic bd;
      run_op(1'b0, 1'b0, 64'd3, 64'd10, dc, bc, bd);
      checks++; if (dc !== EARLY_LAT) begin errors++; $display("FAIL early_latency: got %0d expected %0d", dc, EARLY_LAT); end
      checks++; if (quotient !== 64'h0) begin errors++; $display("FAIL early_quotient: got %h expected 0", quotient); end
      checks++; if (remainder !== 64'd3) begin errors++; $display("FAIL early_remainder: got %h expected 3", remainder); end
   endtask

   task automatic test_divuw;
      int dc, bc; logic bd;
      run_op(1'b0, 1'b1, 64'h00000001FFFFFFFE, 64'd1, dc, bc, bd);
      checks++; if (dc !== 34) begin errors++; $display("FAIL divuw_latency: got %0d expected 34", dc); end
      checks++; if (bc !== 33) begin errors++; $display("FAIL divuw_busy_cycles: got %0d expected 33", bc); end
      checks++; if (quotient !== 64'hFFFFFFFFFFFFFFFE) begin errors++; $display("FAIL divuw_quotient: got %h expected fffffffffffffffe", quotient); end
      checks++; if (remainder !== 64'h0) begin errors++; $display("FAIL divuw_remainder: got %h expected 0", remainder); end
   endtask

   // Runs right after test_divuw, so the held results are -2 / 0.
   task automatic test_flush;
      int dc, bc; logic bd;
      int done_seen;
      logic busy_c20;
      done_seen = 0;
      busy_c20 = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; sign = 1'b0; word = 1'b0; dividend = 64'd1000; divisor = 64'd3;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (done === 1'b1) done_seen++;
         if (c == 20) begin
            busy_c20 = busy;
            flush = 1'b1;
            start = 1'b0;
         end
      end
      @(posedge clk); #1;
      flush = 1'b0;
      if (done === 1'b1) done_seen++;
      $display("flush in cycle 20: cycle21 busy=%0b done_pulses=%0d q=%h r=%h", busy, done_seen, quotient, remainder);
      checks++; if (busy_c20 !== 1'b1) begin errors++; $display("FAIL flush_busy_c20: got %0b expected 1", busy_c20); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_c21: got %0b expected 0", busy); end
      checks++; if (done_seen !== 0) begin errors++; $display("FAIL flush_no_done: got %0d expected 0", done_seen); end
      checks++; if (quotient !== 64'hFFFFFFFFFFFFFFFE) begin errors++; $display("FAIL flush_quotient_held: got %h expected fffffffffffffffe", quotient); end
      checks++; if (remainder !== 64'h0) begin errors++; $display("FAIL flush_remainder_held: got %h expected 0", remainder); end
      // Started in cycle 22, so done in cycle 22 + 66 = 88.
      run_op(1'b0, 1'b0, 64'd1000, 64'd3, dc, bc, bd);
      checks++; if (22 + dc !== 88) begin errors++; $display("FAIL flush_restart_cycle: got %0d expected 88", 22 + dc); end
      checks++; if (quotient !== 64'd333) begin errors++; $display("FAIL flush_restart_quotient: got %h expected 14d", quotient); end
      checks++; if (remainder !== 64'd1) begin errors++; $display("FAIL flush_restart_remainder: got %h expected 1", remainder); end
   endtask

   // The second start is taken in the IDLE cycle right after done.
   task automatic test_back_to_back;
      int dc, bc; logic bd;
      run_op(1'b0, 1'b0, 64'd1000, 64'd10, dc, bc, bd);
      checks++; if (dc !== 66) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 66", dc); end
      checks++; if (quotient !== 64'd100) begin errors++; $display("FAIL b2b_first_quotient: got %h expected 64", quotient); end
      checks++; if (remainder !== 64'd0) begin errors++; $display("FAIL b2b_first_remainder: got %h expected 0", remainder); end
      run_op(1'b1, 1'b1, 64'd7, 64'hFFFFFFFFFFFFFFFD, dc, bc, bd);
      checks++; if (dc !== 34) begin errors++; $display("FAIL b2b_remw_latency: got %0d expected 34", dc); end
      checks++; if (quotient !== 64'hFFFFFFFFFFFFFFFE) begin errors++; $display("FAIL b2b_remw_quotient: got %h expected fffffffffffffffe", quotient); end
      checks++; if (remainder !== 64'd1) begin errors++; $display("FAIL b2b_remw_remainder: got %h expected 1", remainder); end
   endtask

   // Asserting reset mid-operation must clear state without waiting for a clock edge.
   task automatic test_reset_mid;
      @(posedge clk); #1;
      start = 1'b1; sign = 1'b0; word = 1'b0; dividend = 64'd100; divisor = 64'd7;
      repeat (10) @(posedge clk);
      #1 reset_n = 1'b0;
      #2;
      $display("mid-op reset: busy=%0b done=%0b q=%h r=%h", busy, done, quotient, remainder);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %0b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %0b expected 0", done); end
      checks++; if (quotient !== 64'h0) begin errors++; $display("FAIL midreset_quotient: got %h expected 0", quotient); end
      checks++; if (remainder !== 64'h0) begin errors++; $display("FAIL midreset_remainder: got %h expected 0", remainder); end
      start = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_divu();
      test_div_signed();
      test_fast_paths();
      test_early_out();
      test_divuw();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
